approx_mult_pipe: RTL and testbench
===================================

Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit approximate multiplier: WIDTH x WIDTH unsigned operands, 2*WIDTH product.
- The low APPROX_COLS product columns are computed carry-free (XOR of partial products). Upper columns are exact.
- Runtime mode_exact input forces a fully exact product.
- Two-stage valid/ready pipeline. Operand and product registers load only on handshake, giving enable-based clock gating. Sits between the operand source and the accumulator/datapath consumer.

Parameters:
- WIDTH, 8, operand width in bits (2..16).
- APPROX_COLS, 3, number of low product columns computed carry-free (0..WIDTH); 0 = always exact.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier, unsigned.
- mode_exact  input  1  1 = exact product for this operand pair; sampled with operands.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_y  output  2*WIDTH  product.

Behaviour:
- Reset: clk single clock; rst asynchronous active-high. While rst=1: out_valid=0, out_y=0, in_ready=0, both stage-valid flags=0, all data registers=0.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !rst & (!s1_v | !s2_v | out_ready), combinational.
  - out_valid = s2_v.
- Stage 1 (S1): on in_fire, register in_a, in_b and mode_exact; set s1_v. Registers hold when not firing (gated enable).
- Stage 2 (S2): S2 loads the core product from S1 when s1_v & (!s2_v | out_ready). Otherwise it holds.
  - s1_v clears when S1 advances, unless in_fire occurs in the same cycle.
  - s2_v clears on out_fire, unless S1 advances in the same cycle.
- Latency and throughput: out_valid rises 2 cycles after in_fire with no backpressure. Throughput is 1 product/cycle. Order is preserved, with no drop or duplication.
- Backpressure: with out_ready=0 and both stages full, in_ready=0 and out_y stays stable until out_fire.
- Simultaneous out_fire and advance: a full pipeline accepts new operands in the same cycle.
- Arithmetic, with pp(i,j) = a[i]&b[j] and column k = i+j:
  - Exact (mode_exact=1 or APPROX_COLS=0): y = a*b.
  - Approx, columns k < APPROX_COLS: y[k] = XOR of all pp in column k; these columns produce no carries.
  - Approx, upper bits: y[2W-1:APPROX_COLS] = (sum of pp(i,j)*2^(i+j-APPROX_COLS) over i+j >= APPROX_COLS), truncated to 2W-APPROX_COLS bits.
  - The approximate result never exceeds the exact result; the error is bounded by the discarded low-column carries.
- Reset mid-operation discards all in-flight products. No out_valid may appear after rst deasserts until a new in_fire.

Optional Feature:
- Macro: APPROX_MULT_ZERO_SKIP_EN.
- Defined:
  - When the S1 operands have a==0 or b==0, the S2 product register is not enabled (holds its old value).
  - A registered zero flag forces out_y=0. Valid timing is unchanged.
  - Adds output port skip_cnt (16 bits, reset 0): counts S1->S2 advances with a zero operand, saturating at 0xFFFF.
- Undefined: the S2 register always loads on advance; skip_cnt port is absent.
- out_y and valid timing are identical in both builds.

Decomposition:
- Package approx_mult_pkg holds:
  - mode encoding constants (MODE_APPROX=0, MODE_EXACT=1);
  - function max_err(WIDTH, APPROX_COLS) for bench bounds;
  - the skip-counter width localparam.
- One combinational sub-module approx_pp_core (WIDTH, APPROX_COLS; inputs a, b, exact; output y) builds the partial-product columns. The pipeline wrapper holds all sequential logic.

Test Plan:
- WIDTH=8, APPROX_COLS=3; a=0xFF, b=0xFF, mode_exact=0 -> out_y=0xFDF5 two cycles later. Same operands with mode_exact=1 -> 0xFE01.
- a=7, b=7, mode_exact=0 -> out_y=0x0025 (exact 0x0031). a=3, b=5 -> out_y=0x000F in both modes.
- Stream of 20 back-to-back operand pairs with out_ready=1 -> 20 outputs, in order, one per cycle, first at cycle 2 after the first in_fire.
- Hold out_ready=0 for 5 cycles with a stream pending -> in_ready drops once 2 items are held, out_y stable. Release -> no loss or duplicate.
- Assert rst with both stages full -> out_valid=0 and out_y=0 immediately (asynchronous). After deassert, no output appears until a new in_fire.
- APPROX_MULT_ZERO_SKIP_EN: a=0, b=0x5A, then a=0x10, b=0 -> out_y=0 both times, skip_cnt=2. A following nonzero pair gives the correct product.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// ---------------------------------------------------------------------------
// approx_mult_pkg
// Shared definitions for the pipelined approximate multiplier:
//   - MODE_APPROX / MODE_EXACT : encoding of the per-operand mode bit
//   - SKIP_CNT_W               : width of the zero-skip counter
//   - max_err()                : largest possible (exact - approx) difference
//                                for a given operand width and number of
//                                carry-free columns
// ---------------------------------------------------------------------------
package approx_mult_pkg;

    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;

    localparam int SKIP_CNT_W = 16;

    // Column k of a WxW product holds min(k+1, 2W-1-k) partial products. The
    // XOR keeps the parity of that count, so the value lost in the column is
    // the count rounded down to even, weighted by 2^k. The worst case is the
    // all-ones operand pair, where every partial product is 1.
    function automatic int max_err(input int width, input int approx_cols);
        int err;
        int cnt;
        err = 0;
        for (int k = 0; k < approx_cols; k++) begin
            cnt = (k + 1 < 2 * width - 1 - k) ? k + 1 : 2 * width - 1 - k;
            err = err + ((cnt - (cnt % 2)) << k);
        end
        return err;
    endfunction

endpackage

// File: rtl/approx_pp_core.sv
// ---------------------------------------------------------------------------
// approx_pp_core
// Combinational partial-product multiplier core. The low APPROX_COLS product
// columns are formed carry-free (XOR of the column's partial products); all
// higher columns are summed exactly. exact=1 (or APPROX_COLS=0) returns a*b.
//
// Ports:
//   a      in  [WIDTH-1:0]    multiplicand, unsigned
//   b      in  [WIDTH-1:0]    multiplier, unsigned
//   exact  in                 1 = fully exact product
//   y      out [2*WIDTH-1:0]  product
// ---------------------------------------------------------------------------
module approx_pp_core #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 3
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               exact,
    output logic [2*WIDTH-1:0] y
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] hi_sum;   // exact sum of partial products in upper columns
    logic [PW-1:0] lo_par;   // per-column parity of the low columns
    logic [PW-1:0] y_exact;

    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        hi_sum = '0;
        lo_par = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i + j < APPROX_COLS) begin
                    lo_par = lo_par ^ (PW'(a[i] & b[j]) << (i + j));
                end else begin
                    hi_sum = hi_sum + (PW'(a[i] & b[j]) << (i + j));
                end
            end
        end
        y_exact = PW'(a) * PW'(b);
    end

    // hi_sum is a multiple of 2^APPROX_COLS and lo_par lies below it, so OR
    // concatenates the two fields without any carry between them.
    assign y = (exact || (APPROX_COLS == 0)) ? y_exact : (hi_sum | lo_par);

endmodule

// File: rtl/approx_mult_pipe.sv
// ---------------------------------------------------------------------------
// approx_mult_pipe
// Two-stage valid/ready pipelined approximate multiplier.
//   S1: operand registers (a, b, mode), loaded only on in_fire.
//   S2: product register, loaded from approx_pp_core when S1 advances.
// Registers load only on handshake so synthesis can map them to enable-based
// clock gating.
//
// Build option: define APPROX_MULT_ZERO_SKIP_EN to skip loading the product
// register when an operand is zero (a registered zero flag forces out_y=0) and
// to expose skip_cnt. out_y and valid timing are identical in both builds.
//
// Ports:
//   clk         in                 rising-edge clock
//   rst         in                 asynchronous active-high reset
//   in_valid    in                 operand pair valid
//   in_ready    out                pipeline accepts operands this cycle
//   in_a, in_b  in  [WIDTH-1:0]    unsigned operands
//   mode_exact  in                 1 = exact product for this pair
//   out_valid   out                product valid
//   out_ready   in                 consumer accepts product
//   out_y       out [2*WIDTH-1:0]  product
//   skip_cnt    out [15:0]         zero-operand advances, saturating
//                                  (only with APPROX_MULT_ZERO_SKIP_EN)
// ---------------------------------------------------------------------------
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic                  mode_exact,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out_y
`ifdef APPROX_MULT_ZERO_SKIP_EN
    ,
    output logic [SKIP_CNT_W-1:0] skip_cnt
`endif
);

    localparam int PW = 2 * WIDTH;

    logic             s1_v_q, s1_v_d;
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             mode_q;
    logic [PW-1:0]    prod_q;
    logic [PW-1:0]    core_y;

    logic in_fire;
    logic out_fire;
    logic s1_adv;

    // ------------------------------------------------------------------
    // Handshake and stage-valid next state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = !rst && (!s1_v_q || !s2_v_q || out_ready);
        in_fire  = in_valid && in_ready;
        out_fire = s2_v_q && out_ready;
        s1_adv   = s1_v_q && (!s2_v_q || out_ready);

        // A new operand refills S1 in the same cycle it drains.
        s1_v_d = s1_v_q;
        if (in_fire) begin
            s1_v_d = 1'b1;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        // An advancing S1 replaces the product being consumed.
        s2_v_d = s2_v_q;
        if (s1_adv) begin
            s2_v_d = 1'b1;
        end else if (out_fire) begin
            s2_v_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: operand registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    // NOTE: data registers are reset as well as the valid flags, so out_y
    // reads zero during and after reset rather than stale operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_APPROX;
        end else begin
            s1_v_q <= s1_v_d;
            if (in_fire) begin
                a_q    <= in_a;
                b_q    <= in_b;
                mode_q <= mode_exact;
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiplier core between S1 and S2
    // ------------------------------------------------------------------
    approx_pp_core #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_core (
        .a     (a_q),
        .b     (b_q),
        .exact (mode_q == MODE_EXACT),
        .y     (core_y)
    );

    // ------------------------------------------------------------------
    // Stage 2: product register
    // ------------------------------------------------------------------
`ifdef APPROX_MULT_ZERO_SKIP_EN
    logic                  s1_zero;
    logic                  zero_q;
    logic [SKIP_CNT_W-1:0] skip_cnt_q;

    assign s1_zero = (a_q == '0) || (b_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q     <= 1'b0;
            prod_q     <= '0;
            zero_q     <= 1'b0;
            skip_cnt_q <= '0;
        end else begin
            s2_v_q <= s2_v_d;
            if (s1_adv) begin
                zero_q <= s1_zero;
                // A zero operand leaves the product register untouched;
                // zero_q masks its stale contents at the output.
                if (!s1_zero) begin
                    prod_q <= core_y;
                end
                if (s1_zero && (skip_cnt_q != '1)) begin
                    skip_cnt_q <= skip_cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_y    = zero_q ? '0 : prod_q;
    assign skip_cnt = skip_cnt_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q <= 1'b0;
            prod_q <= '0;
        end else begin
            s2_v_q <= s2_v_d;
            if (s1_adv) begin
                prod_q <= core_y;
            end
        end
    end

    assign out_y = prod_q;
`endif

    assign out_valid = s2_v_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_approx_mult_pipe
// Scoreboard bench for approx_mult_pipe (WIDTH=8, APPROX_COLS=3). The driver
// pushes the expected product when an operand pair is accepted; a separate
// monitor pops and compares whenever a product is consumed. Expected values
// come from the arithmetic definition: exact product minus the even part of
// each low column's partial-product count.
// Build option: APPROX_MULT_ZERO_SKIP_EN (adds skip_cnt checks).
// ---------------------------------------------------------------------------
module tb_approx_mult_pipe;
    import approx_mult_pkg::*;

    localparam int W  = 8;
    localparam int C  = 3;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          mode_exact;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_y;
`ifdef APPROX_MULT_ZERO_SKIP_EN
    logic [SKIP_CNT_W-1:0] skip_cnt;
`endif

    approx_mult_pipe #(
        .WIDTH       (W),
        .APPROX_COLS (C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mode_exact (mode_exact),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y)
`ifdef APPROX_MULT_ZERO_SKIP_EN
        ,
        .skip_cnt   (skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [PW-1:0] y;
        logic [PW-1:0] exact_y;
        bit            approx;
        int            fire_cycle;
    } exp_t;

    exp_t sb[$];

    bit lat_check   = 1'b0;
    bit rand_ready  = 1'b0;
    bit ready_force = 1'b1;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // Reference: exact product minus, for each carry-free column, the count
    // of set partial products rounded down to even, weighted by the column.
    function automatic logic [PW-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic exact);
        longint prod;
        longint err;
        int     cnt;
        int     j;
        prod = longint'(a) * longint'(b);
        err  = 0;
        if (!exact) begin
            for (int k = 0; k < C; k++) begin
                cnt = 0;
                for (int i = 0; i < W; i++) begin
                    j = k - i;
                    if (j >= 0 && j < W) begin
                        if (a[i] && b[j]) cnt++;
                    end
                end
                err = err + (longint'(cnt - (cnt % 2)) << k);
            end
        end
        return PW'(prod - err);
    endfunction

    // Consumer-side ready: forced level or random backpressure.
    always begin
        @(negedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'(ready_force);
    end

    // Monitor: samples one time unit before each rising edge.
    exp_t          mon_e;
    logic [PW-1:0] held_y;
    bit            held = 1'b0;

    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && out_valid) check("stable_y_under_backpressure", out_y, held_y);
            held = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", PW'(out_valid), PW'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("out_y", out_y, mon_e.y);
                    if (mon_e.approx)
                        check("approx_within_bound",
                              PW'((out_y <= mon_e.exact_y) &&
                                  (int'(mon_e.exact_y - out_y) <= max_err(W, C))), PW'(1));
                    if (lat_check)
                        check("latency_cycles", PW'(cycle - mon_e.fire_cycle), PW'(2));
                end
            end else if (out_valid) begin
                held   = 1'b1;
                held_y = out_y;
            end
        end
    end

    // Offer one operand pair; returns after the edge that accepts it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                        input bit directed = 1'b0, input logic [PW-1:0] dy = '0);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        mode_exact = mode;
        forever begin
            #4;
            if (in_ready) begin
                e.exact_y    = PW'(a) * PW'(b);
                e.y          = directed ? dy : ref_y(a, b, mode);
                e.approx     = (mode == MODE_APPROX);
                e.fire_cycle = cycle;
                sb.push_back(e);
                break;
            end
            waited++;
            if (waited > 100) begin
                check("in_ready_timeout", PW'(in_ready), PW'(1));
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", PW'(sb.size()), PW'(0));
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        mode_exact = MODE_APPROX;

        // Reset state
        repeat (2) @(negedge clk);
        #4;
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_out_y", out_y, PW'(0));
        check("rst_in_ready", PW'(in_ready), PW'(0));
`ifdef APPROX_MULT_ZERO_SKIP_EN
        check("rst_skip_cnt", PW'(skip_cnt), PW'(0));
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed values, no backpressure, 2-cycle latency
        lat_check = 1'b1;
        send(8'hFF, 8'hFF, MODE_APPROX, 1'b1, 16'hFDF5);
        send(8'hFF, 8'hFF, MODE_EXACT,  1'b1, 16'hFE01);
        send(8'h07, 8'h07, MODE_APPROX, 1'b1, 16'h0025);
        send(8'h07, 8'h07, MODE_EXACT,  1'b1, 16'h0031);
        send(8'h03, 8'h05, MODE_APPROX, 1'b1, 16'h000F);
        send(8'h03, 8'h05, MODE_EXACT,  1'b1, 16'h000F);
        idle();
        drain();

        // 20 back-to-back pairs, one product per cycle
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        idle();
        drain();
        lat_check = 1'b0;

        // Backpressure: hold out_ready low while a stream is pending
        ready_force = 1'b0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
                end
                idle();
            end
            begin
                repeat (5) @(negedge clk);
                #4;
                check("bp_in_ready_low", PW'(in_ready), PW'(0));
                check("bp_out_valid_high", PW'(out_valid), PW'(1));
                ready_force = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure and input gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        idle();
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        drain();

        // Asynchronous reset with both stages full
        ready_force = 1'b0;
        @(negedge clk);
        send(8'hA5, 8'h3C, MODE_EXACT);
        send(8'h5A, 8'hC3, MODE_APPROX);
        idle();
        #4;
        check("full_out_valid", PW'(out_valid), PW'(1));
        check("full_in_ready", PW'(in_ready), PW'(0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", PW'(out_valid), PW'(0));
        check("async_rst_out_y", out_y, PW'(0));
        check("async_rst_in_ready", PW'(in_ready), PW'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        ready_force = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #4;
            check("post_rst_no_out_valid", PW'(out_valid), PW'(0));
        end

        // Zero operands, then a nonzero pair
        lat_check = 1'b1;
        send(8'h00, 8'h5A, MODE_APPROX, 1'b1, 16'h0000);
        send(8'h10, 8'h00, MODE_APPROX, 1'b1, 16'h0000);
        send(8'h12, 8'h34, MODE_EXACT,  1'b1, 16'h03A8);
        send(8'h12, 8'h34, MODE_APPROX);
        idle();
        drain();
        lat_check = 1'b0;
`ifdef APPROX_MULT_ZERO_SKIP_EN
        check("skip_cnt_after_zero_pairs", PW'(skip_cnt), PW'(2));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

endmodule
